// File: rtl/uart_frame_ctrl.sv
// Byte-stream frame decoder: parses FE/LEN/CMD/payload/EF frames from a UART receiver,
// loads matrix/vector memories, holds the configured dimension and launches the datapath.
module uart_frame_ctrl #(
    parameter int TIMEOUT_CYCLES = 8192,
    parameter int MAX_N          = 8
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic [3:0] cfg_n_o,
    output logic       wr_en_o,
    output logic       wr_sel_o,
    output logic [6:0] wr_addr_o,
    output logic [7:0] wr_data_o,
    output logic       mat_ready_o,
    output logic       vec_ready_o,
    output logic       start_o,
    output logic       frame_done_o,
    output logic       frame_err_o
);

    localparam int            TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);

    localparam logic [7:0] SOF       = 8'hFE;
    localparam logic [7:0] EOF       = 8'hEF;
    localparam logic [7:0] CMD_SETN  = 8'h01;
    localparam logic [7:0] CMD_START = 8'h03;
    localparam logic [7:0] CMD_MAT   = 8'h04;
    localparam logic [7:0] CMD_VEC   = 8'h05;

    typedef enum logic [2:0] {IDLE, GET_LEN, GET_CMD, PAYLOAD, GET_END} state_e;

    state_e        state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    pend_q, pend_d;
    logic [3:0]    cfg_n_q, cfg_n_d;
    logic          mat_q, mat_d;
    logic          vec_q, vec_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          wr_en_q, wr_en_d;
    logic          wr_sel_q, wr_sel_d;
    logic [6:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          start_q, start_d;

    logic [7:0] nn;
    logic       cmd_ok;
    logic       last_pl;
    logic       timeout;
    logic       n_ok;

    assign nn      = {4'd0, cfg_n_q} * {4'd0, cfg_n_q};
    assign last_pl = (cnt_q == len_q - 8'd3);
    assign timeout = (state_q != IDLE) && !rx_valid_i && (tmr_q == TMO);
    assign n_ok    = (pend_q != 8'd0) && (pend_q <= 8'(MAX_N));

    // LEN is checked against the command here so PAYLOAD never runs past N*N or N bytes.
    always_comb begin
        cmd_ok = 1'b0;
        case (rx_data_i)
            CMD_SETN:  cmd_ok = (len_q == 8'd3);
            CMD_START: cmd_ok = (len_q == 8'd2);
            CMD_MAT:   cmd_ok = (cfg_n_q != 4'd0) && ({1'b0, len_q} == ({1'b0, nn} + 9'd2));
            CMD_VEC:   cmd_ok = (cfg_n_q != 4'd0) && (len_q == ({4'd0, cfg_n_q} + 8'd2));
            default:   cmd_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = IDLE;
        end else if (rx_valid_i) begin
            case (state_q)
                IDLE:    if (rx_data_i == SOF) state_d = GET_LEN;
                GET_LEN: state_d = (rx_data_i < 8'd2) ? IDLE : GET_CMD;
                GET_CMD: begin
                    if (!cmd_ok)              state_d = IDLE;
                    else if (len_q == 8'd2)   state_d = GET_END;
                    else                      state_d = PAYLOAD;
                end
                PAYLOAD: if (last_pl) state_d = GET_END;
                GET_END: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        len_d     = len_q;
        cmd_d     = cmd_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        cfg_n_d   = cfg_n_q;
        mat_d     = mat_q;
        vec_d     = vec_q;
        wr_en_d   = 1'b0;
        wr_sel_d  = wr_sel_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        start_d   = 1'b0;
        tmr_d     = (rx_valid_i || state_q == IDLE) ? '0 : tmr_q + TW'(1);

        if (timeout) begin
            err_d = 1'b1;
        end else if (rx_valid_i) begin
            case (state_q)
                GET_LEN: begin
                    if (rx_data_i < 8'd2) err_d = 1'b1;
                    else                  len_d = rx_data_i;
                end
                GET_CMD: begin
                    cnt_d = 8'd0;
                    if (cmd_ok) begin
                        cmd_d = rx_data_i;
                        if (rx_data_i == CMD_MAT) mat_d = 1'b0;
                        if (rx_data_i == CMD_VEC) vec_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                PAYLOAD: begin
                    cnt_d = cnt_q + 8'd1;
                    if (cmd_q == CMD_MAT || cmd_q == CMD_VEC) begin
                        wr_en_d   = 1'b1;
                        wr_sel_d  = (cmd_q == CMD_VEC);
                        wr_addr_d = cnt_q[6:0];
                        wr_data_d = rx_data_i;
                    end else begin
                        pend_d = rx_data_i;
                    end
                end
                GET_END: begin
                    if (rx_data_i != EOF) begin
                        err_d = 1'b1;
                    end else begin
                        case (cmd_q)
                            CMD_SETN: begin
                                if (n_ok) begin
                                    done_d  = 1'b1;
                                    cfg_n_d = pend_q[3:0];
                                    mat_d   = 1'b0;
                                    vec_d   = 1'b0;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            CMD_START: begin
                                if (mat_q && vec_q) begin
                                    done_d  = 1'b1;
                                    start_d = 1'b1;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            CMD_MAT: begin
                                done_d = 1'b1;
                                mat_d  = 1'b1;
                            end
                            CMD_VEC: begin
                                done_d = 1'b1;
                                vec_d  = 1'b1;
                            end
                            default: err_d = 1'b1;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            len_q     <= '0;
            cmd_q     <= '0;
            cnt_q     <= '0;
            pend_q    <= '0;
            cfg_n_q   <= '0;
            mat_q     <= 1'b0;
            vec_q     <= 1'b0;
            tmr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_sel_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            len_q     <= len_d;
            cmd_q     <= cmd_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            cfg_n_q   <= cfg_n_d;
            mat_q     <= mat_d;
            vec_q     <= vec_d;
            tmr_q     <= tmr_d;
            wr_en_q   <= wr_en_d;
            wr_sel_q  <= wr_sel_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            start_q   <= start_d;
        end
    end

    assign cfg_n_o      = cfg_n_q;
    assign wr_en_o      = wr_en_q;
    assign wr_sel_o     = wr_sel_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign mat_ready_o  = mat_q;
    assign vec_ready_o  = vec_q;
    assign start_o      = start_q;
    assign frame_done_o = done_q;
    assign frame_err_o  = err_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Scoreboard bench for uart_frame_ctrl: the driver pushes expected write/done/err/start
// events with their cycle; a negedge monitor pops and compares whatever the DUT emits.
module tb_uart_frame_ctrl;

    localparam int T    = 64;
    localparam int MAXN = 8;

    // event mask bits: [0]=wr_en [1]=frame_done [2]=frame_err [3]=start
    localparam logic [3:0] M_NONE = 4'b0000;
    localparam logic [3:0] M_WR   = 4'b0001;
    localparam logic [3:0] M_DONE = 4'b0010;
    localparam logic [3:0] M_ERR  = 4'b0100;
    localparam logic [3:0] M_DST  = 4'b1010;

    typedef struct {
        logic [3:0] mask;
        int         cyc;
        logic       sel;
        logic [6:0] addr;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [3:0] cfg_n;
    logic       wr_en, wr_sel, mat_ready, vec_ready, start, frame_done, frame_err;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;

    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;
    int  last_bcyc = 0;
    ev_t expq[$];

    uart_frame_ctrl #(.TIMEOUT_CYCLES(T), .MAX_N(MAXN)) dut (
        .clk_i(clk), .reset_ni(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .cfg_n_o(cfg_n), .wr_en_o(wr_en), .wr_sel_o(wr_sel), .wr_addr_o(wr_addr),
        .wr_data_o(wr_data), .mat_ready_o(mat_ready), .vec_ready_o(vec_ready),
        .start_o(start), .frame_done_o(frame_done), .frame_err_o(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, %0d events still expected", expq.size());
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [3:0] mask, input int c, input logic s,
                        input logic [6:0] a, input logic [7:0] d);
        ev_t e;
        e.mask = mask; e.cyc = c; e.sel = s; e.addr = a; e.data = d;
        expq.push_back(e);
    endtask

    // Drive one byte; its expected response (if any) is registered one cycle after sampling.
    task automatic tx(input logic [7:0] b, input logic [3:0] mask,
                      input logic [6:0] a = 7'd0, input logic s = 1'b0);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        last_bcyc = cyc + 1;
        if (mask != M_NONE) push(mask, last_bcyc, s, a, b);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] m;
        ev_t e;
        m = {start, frame_err, frame_done, wr_en};
        if (m != 4'b0000) begin
            vectors++;
            if (expq.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event: mask=%b cyc=%0d addr=%0d data=%h", m, cyc, wr_addr, wr_data);
            end else begin
                e = expq.pop_front();
                if (m != e.mask || cyc != e.cyc ||
                    (m[0] && (wr_sel != e.sel || wr_addr != e.addr || wr_data != e.data))) begin
                    miscompares++;
                    $display("FAIL event: got mask=%b cyc=%0d sel=%0d addr=%0d data=%h, expected mask=%b cyc=%0d sel=%0d addr=%0d data=%h",
                             m, cyc, wr_sel, wr_addr, wr_data, e.mask, e.cyc, e.sel, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_cfg_n", cfg_n, 0);
        chk("reset_mat_ready", mat_ready, 0);
        chk("reset_vec_ready", vec_ready, 0);
        chk("reset_wr_en", wr_en, 0);
        rst_n = 1'b1;

        // stray bytes in IDLE are dropped
        tx(8'h55, M_NONE); tx(8'hEF, M_NONE); tx(8'h03, M_NONE);

        // start before anything is loaded
        tx(8'hFE, M_NONE); tx(8'h02, M_NONE); tx(8'h03, M_NONE); tx(8'hEF, M_ERR);

        // matrix with N=0 rejected at CMD
        tx(8'hFE, M_NONE); tx(8'h03, M_NONE); tx(8'h04, M_ERR);

        // set N=4
        tx(8'hFE, M_NONE); tx(8'h03, M_NONE); tx(8'h01, M_NONE); tx(8'h04, M_NONE); tx(8'hEF, M_DONE);
        chk("setn_cfg_n", cfg_n, 4);
        chk("setn_mat_ready", mat_ready, 0);
        chk("setn_vec_ready", vec_ready, 0);

        // 4x4 matrix load
        tx(8'hFE, M_NONE); tx(8'h12, M_NONE); tx(8'h04, M_NONE);
        for (int i = 0; i < 16; i++) tx(8'(i), M_WR, 7'(i), 1'b0);
        tx(8'hEF, M_DONE);
        chk("mat_ready_after_load", mat_ready, 1);
        chk("vec_ready_after_mat", vec_ready, 0);

        // vector load, then start
        tx(8'hFE, M_NONE); tx(8'h06, M_NONE); tx(8'h05, M_NONE);
        for (int i = 0; i < 4; i++) tx(8'(i + 1), M_WR, 7'(i), 1'b1);
        tx(8'hEF, M_DONE);
        chk("vec_ready_after_load", vec_ready, 1);
        tx(8'hFE, M_NONE); tx(8'h02, M_NONE); tx(8'h03, M_NONE); tx(8'hEF, M_DST);

        // bad end byte: writes stay issued, vec_ready cleared when CMD was accepted
        tx(8'hFE, M_NONE); tx(8'h06, M_NONE); tx(8'h05, M_NONE);
        for (int i = 0; i < 4; i++) tx(8'(i + 1), M_WR, 7'(i), 1'b1);
        tx(8'hAA, M_ERR);
        chk("vec_ready_after_bad_end", vec_ready, 0);
        chk("mat_ready_kept", mat_ready, 1);

        // N out of range
        tx(8'hFE, M_NONE); tx(8'h03, M_NONE); tx(8'h01, M_NONE); tx(8'h09, M_NONE); tx(8'hEF, M_ERR);
        chk("bad_n_cfg_unchanged", cfg_n, 4);
        tx(8'hFE, M_NONE); tx(8'h03, M_NONE); tx(8'h01, M_NONE); tx(8'h00, M_NONE); tx(8'hEF, M_ERR);

        // LEN < 2, LEN mismatch, unknown CMD
        tx(8'hFE, M_NONE); tx(8'h01, M_ERR);
        tx(8'hFE, M_NONE); tx(8'h04, M_NONE); tx(8'h04, M_ERR);
        tx(8'hFE, M_NONE); tx(8'h02, M_NONE); tx(8'h07, M_ERR);
        chk("errors_keep_mat_ready", mat_ready, 1);

        // gap of exactly T idle cycles is still accepted
        tx(8'hFE, M_NONE); tx(8'h03, M_NONE);
        repeat (T - 1) @(negedge clk);
        tx(8'h01, M_NONE); tx(8'h03, M_NONE); tx(8'hEF, M_DONE);
        chk("gap_T_cfg_n", cfg_n, 3);

        // gap of T+1 idle cycles times out
        tx(8'hFE, M_NONE); tx(8'h03, M_NONE);
        push(M_ERR, last_bcyc + T + 1, 1'b0, 7'd0, 8'd0);
        repeat (T + 5) @(negedge clk);
        tx(8'hFE, M_NONE); tx(8'h03, M_NONE); tx(8'h01, M_NONE); tx(8'h02, M_NONE); tx(8'hEF, M_DONE);
        chk("after_timeout_cfg_n", cfg_n, 2);

        // 2x2 matrix with FE/EF as data, reset mid-payload
        tx(8'hFE, M_NONE); tx(8'h06, M_NONE); tx(8'h04, M_NONE);
        tx(8'hFE, M_WR, 7'd0, 1'b0); tx(8'hEF, M_WR, 7'd1, 1'b0);
        rst_n = 1'b0;
        tx(8'h33, M_NONE); tx(8'hEF, M_NONE);
        chk("in_reset_cfg_n", cfg_n, 0);
        rst_n = 1'b1;
        tx(8'h44, M_NONE); tx(8'hEF, M_NONE);
        chk("post_reset_mat_ready", mat_ready, 0);
        chk("post_reset_vec_ready", vec_ready, 0);
        tx(8'hFE, M_NONE); tx(8'h02, M_NONE); tx(8'h03, M_NONE); tx(8'hEF, M_ERR);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
